// File: rtl/s444_resp_misr.sv
// s444 response compactor: sequences warm-up, capture and result hold, folding
// the six s444 outputs into a MISR. Optional toggle counter: S444_TOGGLE_CNT_EN.
module s444_resp_misr #(
  parameter int              SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021,
  parameter logic [SIG_W-1:0] SEED = 16'hFFFF,
  parameter int              WARM  = 4,
  parameter int              LEN_W = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic             ACK,
  input  logic             G107,
  input  logic             G108,
  input  logic             G118,
  input  logic             G119,
  input  logic             G167,
  input  logic             G168,
  output logic             BUSY,
  output logic             DONE,
  output logic [SIG_W-1:0] SIG,
  output logic [LEN_W-1:0] TOGL
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_HOLD    = 2'd3;

  localparam int WCNT_W = (WARM > 1) ? $clog2(WARM) : 1;

  logic [1:0]       state;
  logic [WCNT_W-1:0] wcnt;
  logic [LEN_W-1:0] ccnt;
  logic [LEN_W-1:0] len_q;
  logic [SIG_W-1:0] sig_q;
  logic [5:0]       resp;
  logic [SIG_W-1:0] resp_ext;
  logic [SIG_W-1:0] next_sig;
  logic             warm_last;

  assign resp     = {G168, G167, G119, G118, G108, G107};
  assign resp_ext = {{(SIG_W-6){1'b0}}, resp};

  // MISR step: shift out the MSB, fold in the polynomial when it was set.
  assign next_sig = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? POLY : '0)
                  ^ resp_ext;

  // With WARM=0 the WARMUP state is never entered; -1 never matches.
  assign warm_last = (int'(wcnt) == WARM - 1);

  assign BUSY = (state == S_WARMUP) || (state == S_CAPTURE);
  assign DONE = (state == S_HOLD);
  assign SIG  = sig_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= S_IDLE;
      wcnt  <= '0;
      ccnt  <= '0;
      len_q <= '0;
      sig_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            len_q <= LEN;
            sig_q <= SEED;
            wcnt  <= '0;
            ccnt  <= '0;
            if (WARM != 0)     state <= S_WARMUP;
            else if (LEN == '0) state <= S_HOLD;
            else               state <= S_CAPTURE;
          end
        end
        S_WARMUP: begin
          wcnt <= wcnt + 1'b1;
          if (warm_last) begin
            ccnt  <= '0;
            state <= (len_q == '0) ? S_HOLD : S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          sig_q <= next_sig;
          ccnt  <= ccnt + 1'b1;
          // Terminal compare on len_q-1 keeps LEN=all-ones from wrapping.
          if (ccnt == len_q - 1'b1) state <= S_HOLD;
        end
        S_HOLD: begin
          if (ACK) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef S444_TOGGLE_CNT_EN
  logic [5:0]       prev;
  logic [LEN_W-1:0] togl_q;

  always_ff @(posedge CK) begin
    if (RST) begin
      prev   <= '0;
      togl_q <= '0;
    end else begin
      if (state == S_IDLE && START) begin
        togl_q <= '0;
        if (WARM == 0) prev <= resp;
      end
      if (state == S_WARMUP && warm_last) prev <= resp;
      if (state == S_CAPTURE) begin
        prev <= resp;
        if (resp != prev && togl_q != '1) togl_q <= togl_q + 1'b1;
      end
    end
  end

  assign TOGL = togl_q;
`else
  assign TOGL = '0;
`endif

endmodule

// File: tb/tb_s444_resp_misr.sv
// Scoreboard bench for s444_resp_misr: expected signatures are queued at START,
// a monitor compares them when DONE rises.
module tb_s444_resp_misr;

  localparam int WARM = 4;

  logic        CK = 1'b0;
  logic        RST, START, ACK;
  logic [15:0] LEN;
  logic [5:0]  resp;
  logic        BUSY, DONE;
  logic [15:0] SIG, TOGL;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] sig;
    logic [15:0] togl;
  } exp_t;

  exp_t exp_q[$];
  logic done_d = 1'b0;

  always #5 CK = ~CK;

  s444_resp_misr dut (
    .CK(CK), .RST(RST), .START(START), .LEN(LEN), .ACK(ACK),
    .G107(resp[0]), .G108(resp[1]), .G118(resp[2]),
    .G119(resp[3]), .G167(resp[4]), .G168(resp[5]),
    .BUSY(BUSY), .DONE(DONE), .SIG(SIG), .TOGL(TOGL)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare the queued expectation when a result appears.
  always @(negedge CK) begin
    done_d <= DONE;
    if (DONE === 1'b1 && done_d !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sig", 32'(SIG), 32'(e.sig));
        check("togl", 32'(TOGL), 32'(e.togl));
      end
    end
  end

  // Called at posedge+1. resp = wresp during warm-up, then cap[k] per capture cycle.
  // Optionally pulses START and changes LEN mid-run to show both are ignored.
  task automatic run(input logic [15:0] len, input logic [5:0] wresp,
                     input logic [5:0] cap[], input logic [15:0] exp_sig,
                     input logic [15:0] exp_togl, input bit disturb);
    int lat;
    exp_t e;
    e.sig  = exp_sig;
    e.togl = exp_togl;
    exp_q.push_back(e);
    START = 1'b1;
    LEN   = len;
    resp  = wresp;
    @(posedge CK); #1;
    START = 1'b0;
    lat = 1;
    for (int j = 1; j <= 200; j++) begin
      if (j <= WARM) resp = wresp;
      else if (j - WARM - 1 < cap.size()) resp = cap[j - WARM - 1];
      else resp = 6'h00;
      if (disturb && j == 2) begin
        START = 1'b1;
        LEN   = 16'd7;
      end else begin
        START = 1'b0;
      end
      @(posedge CK); #1;
      lat++;
      if (DONE === 1'b1) break;
    end
    START = 1'b0;
    check("latency", 32'(lat), 32'(WARM + int'(len) + 1));
  endtask

  task automatic ack_done();
    ACK = 1'b1;
    @(posedge CK); #1;
    ACK = 1'b0;
    check("done_after_ack", 32'(DONE), 32'd0);
  endtask

  logic [5:0] cap0[];
  logic [5:0] cap1[];
  logic [5:0] cap2[];
  logic [5:0] none[];
`ifdef S444_TOGGLE_CNT_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  initial begin
    cap0 = '{6'h00};
    cap1 = '{6'h3F};
    cap2 = '{6'h00, 6'h3F, 6'h3F, 6'h00};
    none = new[0];
    RST = 1'b1; START = 1'b0; ACK = 1'b0; LEN = '0; resp = '0;
    repeat (2) @(posedge CK);
    #1;
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_sig", 32'(SIG), 32'd0);
    check("rst_togl", 32'(TOGL), 32'd0);
    RST = 1'b0;
    @(posedge CK); #1;

    // Abort mid-capture: no result may appear.
    START = 1'b1; LEN = 16'd10; resp = 6'h15;
    @(posedge CK); #1;
    START = 1'b0;
    repeat (WARM + 3) @(posedge CK);
    #1;
    check("capture_busy", 32'(BUSY), 32'd1);
    RST = 1'b1;
    @(posedge CK); #1;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_sig", 32'(SIG), 32'd0);
    @(posedge CK); #1;
    RST = 1'b0;
    @(posedge CK); #1;

    // One update with resp 00 and 3F.
    run(16'd1, 6'h00, cap0, 16'hEFDF, 16'd0, 1'b0);
    ack_done();
    check("idle_busy", 32'(BUSY), 32'd0);
    run(16'd1, 6'h00, cap1, 16'hEFE0, TOG ? 16'd1 : 16'd0, 1'b0);
    ack_done();

    // LEN=0, START and LEN disturbed while busy.
    run(16'd0, 6'h2A, none, 16'hFFFF, 16'd0, 1'b1);
    ack_done();

    // Four updates with toggles.
    run(16'd4, 6'h00, cap2, 16'h0E9D, TOG ? 16'd2 : 16'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      resp = 6'(i * 7);
      @(posedge CK); #1;
      check("hold_sig", 32'(SIG), 32'h0E9D);
    end
    check("hold_done", 32'(DONE), 32'd1);

    // ACK and START together: ACK only.
    ACK = 1'b1; START = 1'b1;
    @(posedge CK); #1;
    ACK = 1'b0; START = 1'b0;
    check("ackstart_done", 32'(DONE), 32'd0);
    check("ackstart_busy", 32'(BUSY), 32'd0);
    run(16'd1, 6'h00, cap1, 16'hEFE0, TOG ? 16'd1 : 16'd0, 1'b0);
    ack_done();

    repeat (3) @(posedge CK);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
